// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// One quotient bit per cycle; abortable by annul_i; outputs fully registered.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg1_q, neg1_d;
    logic        neg2_q, neg2_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic        neg1_in, neg2_in;
    logic [31:0] abs1, abs2;
    logic [64:0] shifted;
    logic [32:0] diff;
    logic [31:0] quo_fix, rem_fix;

    assign neg1_in = signed_div_i & opdata1_i[31];
    assign neg2_in = signed_div_i & opdata2_i[31];
    assign abs1    = neg1_in ? 32'd0 - opdata1_i : opdata1_i;
    assign abs2    = neg2_in ? 32'd0 - opdata2_i : opdata2_i;

    // Partial remainder lives in [64:32]; the dividend shifts out of [31:0]
    // while quotient bits shift in at bit 0.
    assign shifted = work_q << 1;
    assign diff    = shifted[64:32] - {1'b0, divisor_q};

    // Sign flags are only ever set for signed operations, so unsigned passes through.
    assign quo_fix = (neg1_q ^ neg2_q) ? 32'd0 - work_q[31:0] : work_q[31:0];
    assign rem_fix = neg1_q ? 32'd0 - work_q[63:32] : work_q[63:32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;
        result_d  = result_q;
        ready_d   = ready_q;
        case (state_q)
            FREE: begin
                result_d = 64'h0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'h0) begin
                        state_d = BY_ZERO;
                    end else begin
                        state_d   = ON;
                        cnt_d     = 6'd0;
                        work_d    = {33'h0, abs1};
                        divisor_d = abs2;
                        neg1_d    = neg1_in;
                        neg2_d    = neg2_in;
                    end
                end
            end
            BY_ZERO: begin
                if (annul_i) begin
                    state_d = FREE;
                end else begin
                    state_d  = END;
                    result_d = 64'h0;
                    ready_d  = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_d = FREE;
                    cnt_d   = 6'd0;
                    work_d  = 65'h0;
                end else if (cnt_q == 6'd32) begin
                    state_d  = END;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end else begin
                    // Negative trial difference shows up as a set borrow bit.
                    if (diff[32]) work_d = shifted;
                    else          work_d = {diff, shifted[31:1], 1'b1};
                    cnt_d = cnt_q + 6'd1;
                end
            end
            END: begin
                if (!start_i || annul_i) begin
                    state_d  = FREE;
                    result_d = 64'h0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= 6'd0;
            work_q    <= 65'h0;
            divisor_q <= 32'h0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            result_q  <= 64'h0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic reference model, per-cycle
// output compare, directed corner cases plus randomized operations.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = 32'h0;
    logic [31:0] opdata2_i = 32'h0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    logic        chk_en = 1'b0;
    logic        exp_ready = 1'b0;
    logic [63:0] exp_res = 64'h0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain language-level division; the one signed overflow case
    // is defined to wrap rather than trap.
    function automatic logic [63:0] golden(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'h0) return 64'h0;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Outputs must be 0 whenever not ready, the model result while ready.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", {63'h0, ready_o}, {63'h0, exp_ready});
            chk("result", result_o, exp_ready ? exp_res : 64'h0);
        end
    end

    // Assumes start_i is high and the next rising edge is edge 0.
    task automatic run_from_edge0(input int lat, input logic [63:0] res, input int hold);
        exp_res = res;
        for (int k = 0; k <= lat + hold; k++) begin
            @(posedge clk);
            exp_ready = (k >= lat);
            #1;
            if (k == 0) begin
                // Operand changes after launch must not matter.
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = $urandom_range(0, 1);
            end
        end
        start_i = 1'b0;
        @(posedge clk);
        exp_ready = 1'b0;
        @(posedge clk);
    endtask

    task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input int hold);
        #1;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        run_from_edge0((b == 32'h0) ? 1 : 33, res, hold);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a, b;

        // Reset state
        #2;
        chk("rst_ready", {63'h0, ready_o}, 64'h0);
        chk("rst_result", result_o, 64'h0);
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);

        // Pin the model with hand-computed values
        chk("model_100_7", golden(0, 32'd100, 32'd7), {32'd2, 32'd14});
        chk("model_m7_2", golden(1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model_7_m2", golden(1, 32'd7, 32'hFFFF_FFFE), {32'd1, 32'hFFFF_FFFD});
        chk("model_ovf", golden(1, 32'h8000_0000, 32'hFFFF_FFFF), {32'h0, 32'h8000_0000});
        chk("model_20_3", golden(0, 32'd20, 32'd3), {32'd2, 32'd6});

        // Directed cases with literal expectations
        do_op(0, 32'd100, 32'd7, {32'd2, 32'd14}, 2);
        do_op(1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        do_op(1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1);
        do_op(0, 32'd12345, 32'd0, 64'h0, 1);
        do_op(1, 32'hDEAD_BEEF, 32'd0, 64'h0, 0);
        do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 0);
        do_op(0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 0);

        // Annul during ON: no ready, then a fresh launch works
        #1;
        signed_div_i = 1'b0; opdata1_i = 32'd999; opdata2_i = 32'd5; start_i = 1'b1;
        exp_ready = 1'b0;
        for (int k = 0; k <= 10; k++) @(posedge clk);
        #1 annul_i = 1'b1;
        @(posedge clk);
        #1 annul_i = 1'b0; start_i = 1'b0;
        repeat (3) @(posedge clk);
        do_op(0, 32'd20, 32'd3, {32'd2, 32'd6}, 0);

        // Async reset mid-ON, then relaunch with start held
        #1;
        signed_div_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd7; start_i = 1'b1;
        for (int k = 0; k <= 15; k++) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_on_ready", {63'h0, ready_o}, 64'h0);
        chk("rst_on_result", result_o, 64'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        opdata1_i = 32'hFFFF_FFCE; opdata2_i = 32'd7; signed_div_i = 1'b1;
        run_from_edge0(33, golden(1, 32'hFFFF_FFCE, 32'd7), 0);

        // Async reset while holding a result in END
        #1;
        signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd10; start_i = 1'b1;
        exp_res = {32'd7, 32'd7};
        for (int k = 0; k <= 35; k++) begin
            @(posedge clk);
            exp_ready = (k >= 33);
        end
        #3 rst = 1'b1; exp_ready = 1'b0;
        #1;
        chk("rst_end_ready", {63'h0, ready_o}, 64'h0);
        chk("rst_end_result", result_o, 64'h0);
        start_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'd1;
                2: b = 32'hFFFF_FFFF;
                3: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: a = 32'h8000_0000;
                1: a = $urandom_range(0, 100);
                default: a = $urandom;
            endcase
            do_op(sgn, a, b, golden(sgn, a, b), $urandom_range(0, 3));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. The execute stage launches a division, stalls the pipeline until the result is ready, then forwards the quotient and remainder as the HI/LO write toward the EX/MEM register. The divider uses radix-2 restoring division, one quotient bit per cycle, and can be aborted when the instruction is flushed.

## Interface
- No parameters; operand width fixed at 32 bits (`RegBus`), result width 64 bits (`DoubleRegBus`).
- clk  in  1  pipeline clock, all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- signed_div_i  in  1  1 = signed division (DIV), 0 = unsigned (DIVU); sampled with start_i in FREE.
- opdata1_i  in  32  dividend; sampled with start_i in FREE.
- opdata2_i  in  32  divisor; sampled with start_i in FREE.
- start_i  in  1  request; held high by EX for the whole operation, dropped after ready_o is seen.
- annul_i  in  1  abort current operation (flush/exception).
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid only while ready_o = 1.
- ready_o  out  1  result valid.

## Operation
- States: FREE, BY_ZERO, ON, END.
- FREE: if start_i=1 and annul_i=0: if opdata2_i == 0 go BY_ZERO; else latch operands, go ON with cnt=0. For signed: latch |opdata1_i| and |opdata2_i| (two's-complement negate when bit 31 set); record both sign bits. Otherwise stay; result_o=0, ready_o=0.
- BY_ZERO: next edge go END with result_o = 64'h0.
- ON: if annul_i=1, go FREE immediately (no result). Otherwise one iteration per edge on a 65-bit working register {partial remainder, dividend}: shift left 1; trial-subtract divisor from upper 33 bits; if non-negative keep the difference and set LSB=1, else keep and set LSB=0; cnt increments. When cnt==32 at an edge (no iteration performed): apply sign fix and go END.
- Sign fix (signed only): quotient negated when dividend sign != divisor sign; remainder negated when dividend was negative. Unsigned: no fix.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient wraps to 0x80000000, remainder 0; no exception raised here.
- END: ready_o=1, result_o held. When start_i=0, go FREE, clearing ready_o and result_o to 0. annul_i in END also returns to FREE.
- Reset (any state, any time): state=FREE, cnt=0, working register=0, result_o=0, ready_o=0. Reset mid-operation discards the operation entirely.
- start_i rising while not in FREE is ignored; operands changing after launch have no effect.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Normal division: start_i sampled at edge 0 (FREE->ON), iterations at edges 1..32, sign fix and ON->END at edge 33; ready_o=1 after edge 33, i.e. 34 cycles from the first cycle start_i is high.
- Divide by zero: FREE->BY_ZERO at edge 0, BY_ZERO->END at edge 1; ready_o=1 after edge 1.
- ready_o stays high while start_i=1; falls on the first edge where start_i=0 (END->FREE). A new launch is accepted no earlier than the edge after that.
- annul_i takes effect on the edge where it is sampled; ready_o is never asserted for an annulled operation.
- EX asserts stall request while start_i=1 and ready_o=0; the divider never drives stall itself.

## Test plan
- Unsigned 100 / 7 (signed_div_i=0): ready_o rises after edge 33; result_o = {32'd2, 32'd14}; drop start_i -> ready_o=0, result_o=0 next edge.
- Signed -7 / 2: result_o = {32'hFFFFFFFF, 32'hFFFFFFFD} (r=-1, q=-3); signed 7 / -2 gives {32'd1, 32'hFFFFFFFD}.
- Divisor 0 (any dividend, either mode): ready_o after edge 1, result_o = 64'h0.
- Signed 0x80000000 / 0xFFFFFFFF -> {32'h0, 32'h80000000}; unsigned 0xFFFFFFFF / 1 -> {32'h0, 32'hFFFFFFFF}.
- Annul at cycle 10 of ON: state FREE next edge, ready_o never asserted; fresh launch 20 / 3 then returns {32'd2, 32'd6}.
- Assert rst asynchronously mid-ON (between edges): result_o=0, ready_o=0 immediately; after release with start_i held, a new operation runs full 34-cycle latency.
